pe_out_collector: RTL and testbench

PE_OUT_COLLECTOR -- requirements
Module: pe_out_collector

---
 rtl/pe_array_pkg.sv | 37 +++
 rtl/pe_out_fifo.sv | 65 ++++++
 rtl/pe_out_collector.sv | 171 +++++++++++++++++
 tb/tb_pe_out_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_pkg
// Brief    : Shared sizes, FP16 constants, FSM state type and config clamps
//            for the PE output collector.
// Revision : 1.0 - initial release
// ============================================================================
package pe_array_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_FILTER = 5;

  localparam logic [15:0] ZERO     = 16'h0000;
  localparam logic [15:0] EXP_MASK = 16'h7C00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [2:0] clamp_filter(input logic [2:0] fs);
    if (fs == 3'd0) begin
      return 3'd1;
    end else if (fs > 3'(MAX_FILTER)) begin
      return 3'(MAX_FILTER);
    end else begin
      return fs;
    end
  endfunction

  function automatic logic [2:0] clamp_stride(input logic [2:0] st);
    return (st == 3'd0) ? 3'd1 : st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pe_out_fifo
// Brief    : Synchronous FIFO (power-of-two depth >= 2); a push while full is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pe_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_FULL);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : pe_out_collector
// Brief    : Tags PE array inputs, keeps post-warm-up strided results and
//            buffers them in a FIFO. Optional ReLU via PE_OUT_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pe_out_collector #(
  parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
  parameter int PE_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            filter_size,
  input  logic [2:0]            stride,
  input  logic [7:0]            row_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] PE_Array_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  row_done,
  output logic                  overflow,
  output logic                  busy
);

  import pe_array_pkg::*;

  state_t                r_state;
  logic [2:0]            r_fs_m1;
  logic [2:0]            r_stride;
  logic [7:0]            r_row_len;
  logic [7:0]            r_in_cnt;
  logic [7:0]            r_out_cnt;
  logic [2:0]            r_phase;
  logic [PE_LATENCY-1:0] r_tag_pipe;
  logic                  r_row_done;
  logic                  r_busy;
  logic                  r_overflow;

  logic                  w_tag_in;
  logic                  w_tag_out;
  logic                  w_warm_done;
  logic                  w_keep;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_tag_in    = (r_state == ST_RUN) && in_valid && (r_in_cnt < r_row_len);
  assign w_tag_out   = (r_state == ST_RUN) && r_tag_pipe[PE_LATENCY-1];
  assign w_warm_done = (r_out_cnt >= {5'd0, r_fs_m1});
  assign w_keep      = w_tag_out && w_warm_done && (r_phase == 3'd0);
  assign w_pop       = !w_empty && out_ready;

`ifdef PE_OUT_RELU_EN
  logic w_is_nan;
  assign w_is_nan    = ((PE_Array_out & EXP_MASK) == EXP_MASK) && (PE_Array_out[9:0] != 10'd0);
  assign w_push_data = (PE_Array_out[DATA_WIDTH-1] && !w_is_nan) ? ZERO : PE_Array_out;
`else
  assign w_push_data = PE_Array_out;
`endif

  // Tag pipe mirrors the PE array latency so a tag exits with its result.
  generate
    if (PE_LATENCY > 1) begin : g_tag_shift
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tag_pipe <= '0;
        end else begin
          r_tag_pipe <= {r_tag_pipe[PE_LATENCY-2:0], w_tag_in};
        end
      end
    end else begin : g_tag_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_tag_pipe <= '0;
        end else begin
          r_tag_pipe <= w_tag_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_fs_m1    <= 3'd0;
      r_stride   <= 3'd1;
      r_row_len  <= 8'd0;
      r_in_cnt   <= 8'd0;
      r_out_cnt  <= 8'd0;
      r_phase    <= 3'd0;
      r_row_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_row_done <= 1'b0;
          if (start) begin
            r_fs_m1   <= clamp_filter(filter_size) - 3'd1;
            r_stride  <= clamp_stride(stride);
            r_row_len <= row_len;
            r_in_cnt  <= 8'd0;
            r_out_cnt <= 8'd0;
            r_phase   <= 3'd0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_tag_in) begin
            r_in_cnt <= r_in_cnt + 8'd1;
          end
          if (w_tag_out) begin
            r_out_cnt <= r_out_cnt + 8'd1;
            // Phase only advances once warm-up is over; replaces a modulo.
            if (w_warm_done) begin
              r_phase <= (r_phase == r_stride - 3'd1) ? 3'd0 : r_phase + 3'd1;
            end
          end
          if (r_out_cnt == r_row_len) begin
            r_row_done <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_row_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_row_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_keep && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  pe_out_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_keep),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (out_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign out_valid = !w_empty;
  assign row_done  = r_row_done;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pe_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_out_collector
// Brief    : Directed self-checking bench for pe_out_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_out_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  filter_size = 3'd1;
  logic [2:0]  stride = 3'd1;
  logic [7:0]  row_len = 8'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic [15:0] PE_Array_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        row_done;
  logic        overflow;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] vals [16];
  logic [15:0] got [$];
  int          rd_cnt = 0;

  logic [15:0] pe_p0, pe_p1, pe_p2;

  always #5 clk = ~clk;

  // Behavioural PE array: result appears three cycles after its input.
  always @(posedge clk) begin
    pe_p0 <= in_data;
    pe_p1 <= pe_p0;
    pe_p2 <= pe_p1;
  end
  assign PE_Array_out = pe_p2;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got.push_back(out_data);
    if (reset && row_done) rd_cnt <= rd_cnt + 1;
  end

  pe_out_collector #(
    .DATA_WIDTH (16),
    .PE_LATENCY (3),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .filter_size  (filter_size),
    .stride       (stride),
    .row_len      (row_len),
    .in_valid     (in_valid),
    .PE_Array_out (PE_Array_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .row_done     (row_done),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic run_row(input logic [2:0] fs, input logic [2:0] st, input logic [7:0] len,
                         input int n, output bit timeout);
    @(posedge clk); #1;
    filter_size = fs; stride = st; row_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (row_done !== 1'b0) begin n_fail++; $display("FAIL reset_row_done got=%b exp=0", row_done); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int base, rd0;
    bit to;
    logic [15:0] exp_v [4];
    exp_v[0] = 16'hC000; exp_v[1] = 16'hC400; exp_v[2] = 16'hC600; exp_v[3] = 16'hC800;
    for (int i = 0; i < 4; i++) vals[i] = exp_v[i];
    out_ready = 1'b1; base = got.size(); rd0 = rd_cnt;
    run_row(3'd1, 3'd1, 8'd4, 4, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout busy got=%b exp=0", busy); end
    n_tests++; if (got.size() - base !== 4) begin n_fail++; $display("FAIL basic_count got=%0d exp=4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got[base+i] !== exp_v[i]) begin n_fail++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got[base+i], exp_v[i]); end
    end
    n_tests++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL basic_row_done got=%0d exp=1", rd_cnt - rd0); end
  endtask

  task automatic test_stride;
    int base, rd0;
    bit to;
    for (int i = 0; i < 8; i++) vals[i] = 16'h1000 + 16'(i);
    out_ready = 1'b1; base = got.size(); rd0 = rd_cnt;
    run_row(3'd3, 3'd2, 8'd8, 8, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL stride_timeout busy got=%b exp=0", busy); end
    n_tests++; if (got.size() - base !== 3) begin n_fail++; $display("FAIL stride_count got=%0d exp=3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got[base+i] !== 16'h1002 + 16'(2*i)) begin n_fail++; $display("FAIL stride_data[%0d] got=%h exp=%h", i, got[base+i], 16'h1002 + 16'(2*i)); end
    end
    n_tests++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL stride_row_done got=%0d exp=1", rd_cnt - rd0); end
  endtask

  task automatic test_backpressure;
    int base;
    bit to;
    for (int i = 0; i < 10; i++) vals[i] = 16'h2000 + 16'(i);
    out_ready = 1'b0;
    run_row(3'd1, 3'd1, 8'd10, 10, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout busy got=%b exp=0", busy); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
    n_tests++; if (out_data !== 16'h2000) begin n_fail++; $display("FAIL bp_head got=%h exp=2000", out_data); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_data !== 16'h2000) begin n_fail++; $display("FAIL bp_head_hold got=%h exp=2000", out_data); end
    base = got.size();
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_tests++; if (got.size() - base !== 8) begin n_fail++; $display("FAIL bp_pop_count got=%0d exp=8", got.size() - base); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (got[base+i] !== 16'h2000 + 16'(i)) begin n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got[base+i], 16'h2000 + 16'(i)); end
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_relu;
    int base;
    bit to;
    logic [15:0] exp_v [3];
    vals[0] = 16'hC400; vals[1] = 16'h7E01; vals[2] = 16'h4400;
`ifdef PE_OUT_RELU_EN
    exp_v[0] = 16'h0000;
`else
    exp_v[0] = 16'hC400;
`endif
    exp_v[1] = 16'h7E01; exp_v[2] = 16'h4400;
    out_ready = 1'b1; base = got.size();
    run_row(3'd1, 3'd1, 8'd3, 3, to);
    n_tests++; if (got.size() - base !== 3) begin n_fail++; $display("FAIL relu_count got=%0d exp=3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got[base+i] !== exp_v[i]) begin n_fail++; $display("FAIL relu_data[%0d] got=%h exp=%h", i, got[base+i], exp_v[i]); end
    end
  endtask

  task automatic test_midrow_reset;
    int base;
    bit to;
    out_ready = 1'b0;
    @(posedge clk); #1;
    filter_size = 3'd1; stride = 3'd1; row_len = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h6000 + 16'(i);
      @(posedge clk); #1;
    end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mrr_pre_valid got=%b exp=1", out_valid); end
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrr_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrr_busy got=%b exp=0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mrr_overflow got=%b exp=0", overflow); end
    n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL mrr_out_data got=%h exp=0000", out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) vals[i] = 16'h5000 + 16'(i);
    out_ready = 1'b1; base = got.size();
    run_row(3'd1, 3'd1, 8'd4, 4, to);
    n_tests++; if (got.size() - base !== 4) begin n_fail++; $display("FAIL mrr_rerun_count got=%0d exp=4", got.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got[base+i] !== 16'h5000 + 16'(i)) begin n_fail++; $display("FAIL mrr_rerun_data[%0d] got=%h exp=%h", i, got[base+i], 16'h5000 + 16'(i)); end
    end
  endtask

  task automatic test_edge_config;
    int base;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) vals[i] = 16'h3000 + 16'(i);
    base = got.size();
    run_row(3'd0, 3'd0, 8'd3, 3, to);
    n_tests++; if (got.size() - base !== 3) begin n_fail++; $display("FAIL edge_zero_count got=%0d exp=3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got[base+i] !== 16'h3000 + 16'(i)) begin n_fail++; $display("FAIL edge_zero_data[%0d] got=%h exp=%h", i, got[base+i], 16'h3000 + 16'(i)); end
    end
    for (int i = 0; i < 7; i++) vals[i] = 16'h4000 + 16'(i);
    base = got.size();
    run_row(3'd7, 3'd1, 8'd7, 7, to);
    n_tests++; if (got.size() - base !== 3) begin n_fail++; $display("FAIL edge_fs7_count got=%0d exp=3", got.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got[base+i] !== 16'h4004 + 16'(i)) begin n_fail++; $display("FAIL edge_fs7_data[%0d] got=%h exp=%h", i, got[base+i], 16'h4004 + 16'(i)); end
    end
    base = got.size();
    @(posedge clk); #1;
    filter_size = 3'd1; stride = 3'd1; row_len = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL len0_busy got=%b exp=1", busy); end
    n_tests++; if (row_done !== 1'b0) begin n_fail++; $display("FAIL len0_early_done got=%b exp=0", row_done); end
    @(posedge clk); #1;
    n_tests++; if (row_done !== 1'b1) begin n_fail++; $display("FAIL len0_row_done got=%b exp=1", row_done); end
    @(posedge clk); #1;
    n_tests++; if (row_done !== 1'b0) begin n_fail++; $display("FAIL len0_done_pulse got=%b exp=0", row_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle got=%b exp=0", busy); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (got.size() - base !== 0) begin n_fail++; $display("FAIL len0_outputs got=%0d exp=0", got.size() - base); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_relu();
    test_midrow_reset();
    test_edge_config();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
